// File: rtl/chnl_rx_demux_if.sv
// Bundle of the RIFFA CHNL RX handshake and the per-destination output streams.
// slave is the demux view; master is the host/consumer view.
interface chnl_rx_demux_if #(
    parameter int unsigned C_PCI_DATA_WIDTH = 32,
    parameter int unsigned NUM_DEST         = 4
);
    logic                        CHNL_RX;
    logic                        CHNL_RX_ACK;
    logic                        CHNL_RX_LAST;
    logic [31:0]                 CHNL_RX_LEN;
    logic [30:0]                 CHNL_RX_OFF;
    logic [C_PCI_DATA_WIDTH-1:0] CHNL_RX_DATA;
    logic                        CHNL_RX_DATA_VALID;
    logic                        CHNL_RX_DATA_REN;
    logic [NUM_DEST-1:0]         o_val;
    logic [NUM_DEST-1:0]         o_rdy;
    logic [C_PCI_DATA_WIDTH-1:0] o_data;
    logic                        o_last;

    modport slave (
        input  CHNL_RX, CHNL_RX_LAST, CHNL_RX_LEN, CHNL_RX_OFF, CHNL_RX_DATA,
               CHNL_RX_DATA_VALID, o_rdy,
        output CHNL_RX_ACK, CHNL_RX_DATA_REN, o_val, o_data, o_last
    );

    modport master (
        output CHNL_RX, CHNL_RX_LAST, CHNL_RX_LEN, CHNL_RX_OFF, CHNL_RX_DATA,
               CHNL_RX_DATA_VALID, o_rdy,
        input  CHNL_RX_ACK, CHNL_RX_DATA_REN, o_val, o_data, o_last
    );
endinterface

// File: rtl/chnl_rx_demux.sv
// Routes each RIFFA CHNL RX transaction to one of NUM_DEST consumers chosen by its header beat.
// Define CHNL_RX_DEMUX_STATS_EN to build the drop/abort statistics counters.
module chnl_rx_demux #(
    parameter int unsigned C_PCI_DATA_WIDTH = 32,
    parameter int unsigned NUM_DEST         = 4,
    parameter int unsigned DEST_W           = 2
) (
    input  logic           clk,
    input  logic           rst,
    output logic           CHNL_RX_CLK,
    chnl_rx_demux_if.slave bus,
    output logic           busy,
    output logic [15:0]    drop_cnt,
    output logic [15:0]    abort_cnt
);
    localparam int unsigned Wpb     = C_PCI_DATA_WIDTH / 32;
    localparam int unsigned WpbLog2 = $clog2(Wpb);

    typedef enum logic [2:0] {
        StIdle,
        StOpening,
        StOpenHdr,
        StData,
        StDiscard,
        StDrain
    } state_e;

    state_e              state_q, state_d;
    logic [31:0]         rem_q, rem_d;
    logic [DEST_W-1:0]   dest_q, dest_d;
    logic                ack_q, ack_d;
    logic [31:0]         beats;
    logic [DEST_W-1:0]   hdr_dest;
    logic                hdr_ok;
    logic [NUM_DEST-1:0] sel;
    logic [NUM_DEST-1:0] val;
    logic                ren;
    logic                drop_evt;
    logic                abort_evt;
    logic                unused_in;

    // Word count rounded up to whole beats; wraps in 32 bits like the host counter.
    assign beats    = (bus.CHNL_RX_LEN + 32'(Wpb - 1)) >> WpbLog2;
    assign hdr_dest = bus.CHNL_RX_DATA[DEST_W-1:0];
    assign hdr_ok   = 32'(hdr_dest) < NUM_DEST;

    assign CHNL_RX_CLK          = clk;
    assign bus.CHNL_RX_ACK      = ack_q;
    assign bus.CHNL_RX_DATA_REN = ren;
    assign bus.o_val            = val;
    assign bus.o_data           = bus.CHNL_RX_DATA;
    assign bus.o_last           = (state_q == StData) && (rem_q == 32'd1);
    assign busy                 = (state_q != StIdle);
    assign unused_in            = ^{bus.CHNL_RX_LAST, bus.CHNL_RX_OFF};

    always_comb begin
        sel = '0;
        for (int unsigned i = 0; i < NUM_DEST; i++) begin
            sel[i] = (32'(dest_q) == i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            rem_q   <= '0;
            dest_q  <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            dest_q  <= dest_d;
            ack_q   <= ack_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        dest_d    = dest_q;
        ack_d     = 1'b0;
        ren       = 1'b0;
        val       = '0;
        drop_evt  = 1'b0;
        abort_evt = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.CHNL_RX) state_d = StOpening;
            end
            StOpening: begin
                if (bus.CHNL_RX) begin
                    ack_d = 1'b1;
                    if (beats == 32'd0) begin
                        state_d = StDrain;
                    end else begin
                        state_d = StOpenHdr;
                        rem_d   = beats;
                    end
                end else begin
                    state_d = StIdle;
                end
            end
            StOpenHdr: begin
                if (!bus.CHNL_RX) begin
                    abort_evt = 1'b1;
                    state_d   = StIdle;
                end else begin
                    ren = bus.CHNL_RX_DATA_VALID;
                    if (ren) begin
                        dest_d = hdr_dest;
                        rem_d  = rem_q - 32'd1;
                        if (rem_q == 32'd1) begin
                            state_d = StDrain;
                        end else if (hdr_ok) begin
                            state_d = StData;
                        end else begin
                            state_d  = StDiscard;
                            drop_evt = 1'b1;
                        end
                    end
                end
            end
            StData, StDiscard: begin
                if (!bus.CHNL_RX) begin
                    abort_evt = 1'b1;
                    state_d   = StIdle;
                end else begin
                    if (state_q == StData) begin
                        val = sel & {NUM_DEST{bus.CHNL_RX_DATA_VALID}};
                        ren = bus.CHNL_RX_DATA_VALID & |(bus.o_rdy & sel);
                    end else begin
                        ren = bus.CHNL_RX_DATA_VALID;
                    end
                    if (ren) begin
                        rem_d = rem_q - 32'd1;
                        if (rem_q == 32'd1) state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                // Beats beyond the announced length are swallowed until the host closes.
                ren = bus.CHNL_RX_DATA_VALID;
                if (!bus.CHNL_RX) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

`ifdef CHNL_RX_DEMUX_STATS_EN
    logic [15:0] drop_q;
    logic [15:0] abort_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_q  <= '0;
            abort_q <= '0;
        end else begin
            if (drop_evt && (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'd1;
            if (abort_evt && (abort_q != 16'hFFFF)) abort_q <= abort_q + 16'd1;
        end
    end

    assign drop_cnt  = drop_q;
    assign abort_cnt = abort_q;
`else
    logic unused_evt;

    assign unused_evt = drop_evt ^ abort_evt;
    assign drop_cnt   = 16'd0;
    assign abort_cnt  = 16'd0;
`endif

endmodule

// File: doc/chnl_rx_demux.md
# chnl_rx_demux

Transaction-level dispatcher for one RIFFA CHNL receive channel. It handshakes with the host, reads a one-beat routing header at the start of each transaction, and forwards the remaining beats to one of NUM_DEST downstream stream consumers. It sits between the RIFFA endpoint and several independent RX consumers, such as command, instruction and configuration sinks, so they can share one PCIe channel.

## Interface
- C_PCI_DATA_WIDTH, 32: CHNL data width; must be 32, 64 or 128.
- NUM_DEST, 4: number of downstream consumers; 2..16.
- DEST_W, 2: header destination field width; must satisfy 2^DEST_W ≥ NUM_DEST.

- clk  in  1  clock; also driven out on CHNL_RX_CLK.
- rst  in  1  reset, asynchronous, active-high.
- CHNL_RX_CLK  out  1  equals clk.
- CHNL_RX  in  1  host transaction open.
- CHNL_RX_ACK  out  1  transaction accept pulse.
- CHNL_RX_LAST  in  1  ignored.
- CHNL_RX_LEN  in  32  transaction length in 32-bit words.
- CHNL_RX_OFF  in  31  ignored.
- CHNL_RX_DATA  in  C_PCI_DATA_WIDTH  receive data.
- CHNL_RX_DATA_VALID  in  1  data beat present.
- CHNL_RX_DATA_REN  out  1  data beat consumed.
- o_val  out  NUM_DEST  per-destination valid; one-hot or zero.
- o_rdy  in  NUM_DEST  per-destination ready.
- o_data  out  C_PCI_DATA_WIDTH  shared data bus; equals CHNL_RX_DATA.
- o_last  out  1  current beat is the final beat of the transaction.
- busy  out  1  state is not S_IDLE.
- drop_cnt  out  16  count of transactions dropped because of an invalid destination.
- abort_cnt  out  16  count of transactions closed before completion.

## Operation
- WPB = C_PCI_DATA_WIDTH/32 words per beat.
- beats = (CHNL_RX_LEN + WPB − 1) >> log2(WPB), computed in 32-bit arithmetic. It is latched into rem_beats when the design enters S_OPEN_HDR.
- Header beat format:
  - CHNL_RX_DATA[DEST_W-1:0] is the destination.
  - All other bits in the header beat are ignored. The header consumes a whole beat.
- States and transitions:
  - S_IDLE: go to S_OPENING when CHNL_RX=1.
  - S_OPENING:
    - If CHNL_RX=1: assert CHNL_RX_ACK for one cycle. Go to S_DRAIN if beats=0, otherwise S_OPEN_HDR.
    - If CHNL_RX=0: return to S_IDLE.
  - S_OPEN_HDR:
    - CHNL_RX_DATA_REN = CHNL_RX_DATA_VALID.
    - On a consumed beat: latch dest and decrement rem_beats.
    - If rem_beats was 1, go to S_DRAIN.
    - Otherwise go to S_DATA when dest < NUM_DEST, or S_DISCARD when dest ≥ NUM_DEST. Taking S_DISCARD increments drop_cnt.
  - S_DATA:
    - o_val[dest] = CHNL_RX_DATA_VALID.
    - CHNL_RX_DATA_REN = CHNL_RX_DATA_VALID & o_rdy[dest].
    - On a consumed beat, decrement rem_beats. When rem_beats was 1, go to S_DRAIN.
  - S_DISCARD: CHNL_RX_DATA_REN = CHNL_RX_DATA_VALID. Count beats as in S_DATA, with no o_val.
  - S_DRAIN:
    - CHNL_RX_DATA_REN = CHNL_RX_DATA_VALID; excess beats are discarded.
    - Go to S_IDLE when CHNL_RX=0.
- Abort:
  - CHNL_RX=0 in S_OPEN_HDR, S_DATA or S_DISCARD gives an immediate return to S_IDLE.
  - abort_cnt increments.
  - o_val and CHNL_RX_DATA_REN are forced to 0 in that cycle.
- o_last = 1 whenever rem_beats==1 in S_DATA.
- o_val bits other than o_val[dest] are always 0.
- Counters saturate at 16'hFFFF.

## Timing
- All outputs are 0 at reset: ACK, REN, o_val, o_last, busy, drop_cnt and abort_cnt. state=S_IDLE, rem_beats=0, dest=0.
- Reset asserted mid-transaction returns the block to S_IDLE asynchronously. Counters clear.
- Forwarding has zero latency: o_val, o_data and REN are combinational from CHNL_RX_DATA_VALID, CHNL_RX_DATA and o_rdy. No data is stored.
- Handshakes:
  - A beat transfers in a cycle where valid & rdy are both high.
  - Back-pressure from o_rdy[dest] holds REN low. The beat stays on CHNL_RX_DATA.
- ACK timing: ACK is asserted exactly one cycle, 2 cycles after the CHNL_RX rising edge is sampled in S_IDLE.
- The first header beat can be consumed in the cycle after ACK.
- The final data beat moves the design to S_DRAIN on the next edge.
- A new transaction can start no earlier than 1 cycle after CHNL_RX falls.

## Configuration
- CHNL_RX_DEMUX_STATS_EN defined: drop_cnt and abort_cnt operate as specified.
- CHNL_RX_DEMUX_STATS_EN undefined:
  - The counter registers are not instantiated. drop_cnt and abort_cnt are tied to 16'd0.
  - Routing behaviour is identical, including discard of invalid destinations.

## Test plan
- Routing:
  - Stimulus: C_PCI_DATA_WIDTH=32, LEN=5, header=2, data 0xA..0xD, o_rdy=4'b1111.
  - Response: ACK pulse, four beats on o_val[2], o_last on 0xD, REN count=5, busy drops after CHNL_RX falls.
- Back-pressure:
  - Stimulus: LEN=4 to dest 1. o_rdy[1] is held low 3 cycles mid-stream.
  - Response: REN=0 and o_val[1]=1 with stable data while stalled. No beat is lost or duplicated.
- Invalid destination:
  - Stimulus: NUM_DEST=3, header=3, LEN=6.
  - Response: all 6 beats consumed, o_val stays 0, drop_cnt=1.
- Width rounding and header-only:
  - Stimulus: C_PCI_DATA_WIDTH=64, first LEN=5, then LEN=2.
  - Response for LEN=5: beats=3, two beats forwarded.
  - Response for LEN=2: header only, no o_val, direct to S_DRAIN.
- Abort and reset:
  - Stimulus: CHNL_RX drops after the 2nd of 8 data beats. Then, in a separate run, rst is pulsed in S_DATA.
  - Response to the abort: S_IDLE, abort_cnt=1, o_val=0 the same cycle.
  - Response to the reset: all outputs 0 and the counters cleared.
- Zero length:
  - Stimulus: LEN=0.
  - Response: ACK, then S_DRAIN, with no REN needed. A following transaction to dest 0 routes normally.
